// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the idle line level.
// Imported by the transmitter; the receiver uses the same idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Character handshake and serial line bundle for uart_tx.
// master = character source, slave = transmitter.
interface uart_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_tx;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_tx,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 while enabled, wraps and
// flags o_bit_tick on the wrap cycle. Clear has priority and holds the
// count at 0. o_cnt is exposed for mid-bit / early-end comparisons.
module uart_baud_gen #(
    parameter int unsigned CLK_PER_BIT = 434
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic                           i_clr,
    output logic                           o_bit_tick,
    output logic [$clog2(CLK_PER_BIT)-1:0] o_cnt
);
    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    // Next count: clear, wrap on the last cycle of a bit, or increment.
    always_comb begin
        tick  = i_en && (cnt_q == CNT_W'(CLK_PER_BIT - 1));
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_tick = tick;
    assign o_cnt      = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start(0), DATA_W data bits LSB first, optional even
// parity, STOP_BITS stop bits. All outputs are registered.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and
// its parity flop).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 434,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_tx_if.slave bus
);
    localparam int unsigned CNT_W     = $clog2(CLK_PER_BIT);
    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

    uart_state_e          state_q, state_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic             bit_tick;
    logic [CNT_W-1:0] baud_cnt;
    logic             stop_last;

    uart_baud_gen #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_baud (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (state_q != IDLE),
        .i_clr      (state_q == IDLE),
        .o_bit_tick (bit_tick),
        .o_cnt      (baud_cnt)
    );

    assign stop_last = (STOP_BITS == 1) || stop_idx_q;

    // Frame sequencing. STOP leaves one cycle before its nominal end: the
    // IDLE/o_done cycle keeps the line high and serves as the final stop
    // cycle, so an accept on that cycle follows with no idle gap.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LVL;
                if (bus.i_valid) begin
                    state_d  = START;
                    shift_d  = bus.i_data;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.i_data;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d  = '0;
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
                        tx_d       = parity_q;
`else
                        state_d    = STOP;
                        tx_d       = UART_IDLE_LVL;
                        stop_idx_d = 1'b0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    tx_d       = UART_IDLE_LVL;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                tx_d = UART_IDLE_LVL;
                if (stop_last && (baud_cnt == CNT_W'(CLK_PER_BIT - 2))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bit_tick) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = UART_IDLE_LVL;
            end
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset abandons any frame without o_done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= UART_IDLE_LVL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.o_tx    = tx_q;
    assign bus.o_ready = ready_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLK_PER_BIT=4, DATA_W=8, STOP_BITS=1).
// A line monitor captures every frame cycle by cycle and compares it with
// the scoreboard entry pushed when the character was offered.
module tb_uart_tx;
    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_LEN = (1 + DW + PBITS + 1) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if #(.DATA_W(DW)) bus ();

    uart_tx #(
        .CLK_PER_BIT(CPB),
        .DATA_W     (DW),
        .STOP_BITS  (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t exp_q[$];

    // Per-cycle line model: bit index b = cycle / CPB.
    function automatic logic [63:0] frame_model(input logic [7:0] d, input logic p);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < FRAME_LEN; c++) begin
            int b;
            b = c / CPB;
            if (b == 0)                            v[c] = 1'b0;
            else if (b <= DW)                      v[c] = d[b-1];
            else if (PBITS == 1 && b == DW + 1)    v[c] = p;
            else                                   v[c] = 1'b1;
        end
        return v;
    endfunction

    // Line monitor
    logic        mon_active = 1'b0;
    int          mon_cyc    = 0;
    logic [63:0] mon_tx, mon_done;
    int          idle_run   = 0;
    int          last_gap   = 0;
    int          stray_done = 0;
    int          done_pulses = 0;

    always @(negedge clk) begin
        if (bus.o_done === 1'b1) done_pulses++;
        if (rst) begin
            if (mon_active && exp_q.size() > 0) void'(exp_q.pop_front());
            mon_active = 1'b0;
            idle_run   = 0;
        end else begin
            if (!mon_active && bus.o_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
                mon_tx     = '0;
                mon_done   = '0;
                last_gap   = idle_run;
                idle_run   = 0;
            end
            if (mon_active) begin
                mon_tx[mon_cyc]   = bus.o_tx;
                mon_done[mon_cyc] = bus.o_done;
                mon_cyc++;
                if (mon_cyc == FRAME_LEN) begin
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%h required=none", mon_tx);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("frame_bits", mon_tx, frame_model(e.data, e.par));
                        check("frame_done", mon_done, 64'(1) << (FRAME_LEN - 1));
                    end
                end
            end else begin
                idle_run++;
                if (bus.o_done === 1'b1) stray_done++;
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        exp_q.push_back(e);
    endtask

    // Offer a character and wait (bounded) for the accepting edge.
    task automatic accept(input logic [7:0] d, input bit hold);
        bit ok;
        ok          = 1'b0;
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!hold) bus.i_valid = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 64'(ok), 64'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_tx, bad_rdy, bad_busy, bad_done, rdy_hi, dp0, sd0, low_cnt;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h80, 1'b1};

        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and 20 idle cycles
        @(negedge clk);
        check("rst_tx",    64'(bus.o_tx),    64'd1);
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        check("rst_busy",  64'(bus.o_busy),  64'd0);
        check("rst_done",  64'(bus.o_done),  64'd0);
        bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.o_tx    !== 1'b1) bad_tx++;
            if (bus.o_ready !== 1'b1) bad_rdy++;
            if (bus.o_busy  !== 1'b0) bad_busy++;
            if (bus.o_done  !== 1'b0) bad_done++;
        end
        check("idle_tx",    64'(bad_tx),   64'd0);
        check("idle_ready", 64'(bad_rdy),  64'd0);
        check("idle_busy",  64'(bad_busy), 64'd0);
        check("idle_done",  64'(bad_done), 64'd0);
        @(posedge clk);
        #1;

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].data, vecs[i].par);
            accept(vecs[i].data, 1'b0);
            @(negedge clk);
            check("busy_after_accept",  64'(bus.o_busy),  64'd1);
            check("ready_after_accept", 64'(bus.o_ready), 64'd0);
            wait_idle();
            check("ready_after_frame", 64'(bus.o_ready), 64'd1);
            check("busy_after_frame",  64'(bus.o_busy),  64'd0);
            @(posedge clk);
            #1;
        end

        // Back-to-back with i_valid held across the o_done cycle
        dp0 = done_pulses;
        push_exp(8'h55, 1'b0);
        push_exp(8'h0F, 1'b0);
        accept(8'h55, 1'b1);
        bus.i_data = 8'h0F;
        accept(8'h0F, 1'b0);
        wait_idle();
        check("b2b_gap",  64'(last_gap), 64'd0);
        check("b2b_done", 64'(done_pulses - dp0), 64'd2);
        @(posedge clk);
        #1;

        // Reset during DATA bit 3
        dp0 = done_pulses;
        push_exp(8'hC3, 1'b0);
        accept(8'hC3, 1'b0);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_tx",    64'(bus.o_tx),    64'd1);
        check("midrst_ready", 64'(bus.o_ready), 64'd1);
        check("midrst_busy",  64'(bus.o_busy),  64'd0);
        repeat (48) @(negedge clk);
        check("midrst_no_done", 64'(done_pulses - dp0), 64'd0);
        check("midrst_queue",   64'(exp_q.size()),      64'd0);
        @(posedge clk);
        #1;
        push_exp(8'h3C, 1'b0);
        accept(8'h3C, 1'b0);
        wait_idle();
        @(posedge clk);
        #1;

        // Inputs toggled while busy are ignored
        push_exp(8'h96, 1'b0);
        accept(8'h96, 1'b0);
        rdy_hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.o_ready !== 1'b0) rdy_hi++;
            bus.i_data  = 8'($urandom);
            bus.i_valid = 1'($urandom_range(0, 1));
        end
        bus.i_valid = 1'b0;
        check("busy_ready_low", 64'(rdy_hi), 64'd0);
        wait_idle();
        @(posedge clk);
        #1;

        // Reset coincident with an offered character: nothing latched
        sd0 = stray_done;
        bus.i_data  = 8'hAA;
        bus.i_valid = 1'b1;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1) low_cnt++;
        end
        check("rst_accept_tx", 64'(low_cnt), 64'd0);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        check("stray_done",  64'(stray_done - sd0 + sd0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
